// File: rtl/mono_pkg.sv
// ---------------------------------------------------------------------------
// mono_pkg
// Shared definitions for the MONOPIX serial readout emulator: hit word field
// widths, the transmitter FSM state encoding and a saturating counter helper.
// ---------------------------------------------------------------------------
package mono_pkg;

    localparam int MONO_WORD_W = 27;
    localparam int COL_W       = 6;
    localparam int ROW_W       = 9;
    localparam int TS_W        = 6;

    // Transmitter sequence: hit loaded on READ rise, waits for READ fall,
    // counts out the data delay, then shifts the word MSB-first.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SHIFT  = 2'd3
    } tx_state_t;

    // 8-bit increment that holds at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gray6_encode.sv
// ---------------------------------------------------------------------------
// gray6_encode
// Combinational 6-bit binary to Gray-code converter.
// Ports:
//   bin  in  6  binary value
//   gray out 6  Gray-coded value, gray[5]=bin[5], gray[i]=bin[i+1]^bin[i]
// ---------------------------------------------------------------------------
module gray6_encode (
    input  logic [5:0] bin,
    output logic [5:0] gray
);

    assign gray = bin ^ {1'b0, bin[5:1]};

endmodule

// File: rtl/mono_data_tx_emu.sv
// ---------------------------------------------------------------------------
// mono_data_tx_emu
// Chip-side emulator of the MONOPIX token/freeze/read serial readout.
// Injected hits are queued in a small FIFO; RX_TOKEN advertises pending hits
// (or, while frozen, the hits that were pending when FREEZE rose). Each
// RX_READ pulse pops one hit, and after READ falls the 27-bit word
// {col, le, te, row} is shifted out MSB-first on RX_DATA.
// Ports:
//   RX_CLK          in   1          readout clock
//   RST_N           in   1          synchronous active-low reset
//   HIT_WR          in   1          write one hit into the FIFO
//   HIT_COL/ROW     in   6/9        hit address
//   HIT_LE/HIT_TE   in   6/6        binary timestamps
//   CONF_GRAY_EN    in   1          transmit LE/TE Gray-coded when 1
//   RX_FREEZE       in   1          freeze from the receiver
//   RX_READ         in   1          read strobe from the receiver
//   RX_TOKEN        out  1          hits pending (registered)
//   RX_DATA         out  1          serial data (registered)
//   HIT_FULL        out  1          FIFO full
//   PENDING         out  FIFO_AW+1  FIFO occupancy
//   LOST_CNT        out  8          hits dropped on full FIFO, saturating
//   EMPTY_READ_CNT  out  8          READ pulses with an empty FIFO, saturating
// ---------------------------------------------------------------------------
module mono_data_tx_emu
    import mono_pkg::*;
#(
    parameter int FIFO_AW    = 4,
    parameter int DATA_DELAY = 1
) (
    input  logic               RX_CLK,
    input  logic               RST_N,
    input  logic               HIT_WR,
    input  logic [5:0]         HIT_COL,
    input  logic [8:0]         HIT_ROW,
    input  logic [5:0]         HIT_LE,
    input  logic [5:0]         HIT_TE,
    input  logic               CONF_GRAY_EN,
    input  logic               RX_FREEZE,
    input  logic               RX_READ,
    output logic               RX_TOKEN,
    output logic               RX_DATA,
    output logic               HIT_FULL,
    output logic [FIFO_AW:0]   PENDING,
    output logic [7:0]         LOST_CNT,
    output logic [7:0]         EMPTY_READ_CNT
);

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_P  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] ZERO_P   = (FIFO_AW + 1)'(0);
    localparam logic [FIFO_AW:0] ONE_P    = (FIFO_AW + 1)'(1);
    localparam logic [3:0]       DLY_LOAD = 4'(DATA_DELAY - 1);
    localparam logic [4:0]       TOP_BIT  = 5'(MONO_WORD_W - 1);

    // Hit storage holds the raw binary word; Gray coding is applied on pop so
    // CONF_GRAY_EN takes effect at transmit time.
    logic [MONO_WORD_W-1:0] mem_r [DEPTH];
    logic [FIFO_AW:0]       wr_ptr_r;
    logic [FIFO_AW:0]       rd_ptr_r;
    logic [FIFO_AW:0]       pending_r;
    logic [FIFO_AW:0]       pending_nxt_s;
    logic                   full_r;
    logic [7:0]             lost_cnt_r;
    logic [7:0]             empty_cnt_r;
    logic                   read_q_r;
    logic                   freeze_q_r;
    logic [FIFO_AW:0]       frz_cnt_r;
    logic                   token_r;
    tx_state_t              state_r;
    logic [MONO_WORD_W-1:0] shreg_r;
    logic [3:0]             dcnt_r;
    logic [4:0]             bcnt_r;
    logic                   data_r;

    logic                   read_rise_s;
    logic                   read_fall_s;
    logic                   frz_rise_s;
    logic                   wr_s;
    logic                   pop_s;
    logic [MONO_WORD_W-1:0] head_s;
    logic [COL_W-1:0]       head_col_s;
    logic [TS_W-1:0]        head_le_s;
    logic [TS_W-1:0]        head_te_s;
    logic [ROW_W-1:0]       head_row_s;
    logic [TS_W-1:0]        le_gray_s;
    logic [TS_W-1:0]        te_gray_s;
    logic [TS_W-1:0]        le_tx_s;
    logic [TS_W-1:0]        te_tx_s;
    logic [MONO_WORD_W-1:0] word_s;

    assign read_rise_s = RX_READ & ~read_q_r;
    assign read_fall_s = ~RX_READ & read_q_r;
    assign frz_rise_s  = RX_FREEZE & ~freeze_q_r;

    assign head_s     = mem_r[rd_ptr_r[FIFO_AW-1:0]];
    assign head_col_s = head_s[26:21];
    assign head_le_s  = head_s[20:15];
    assign head_te_s  = head_s[14:9];
    assign head_row_s = head_s[8:0];

    gray6_encode u_gray_le (
        .bin  (head_le_s),
        .gray (le_gray_s)
    );

    gray6_encode u_gray_te (
        .bin  (head_te_s),
        .gray (te_gray_s)
    );

    // Pop/write qualification, next occupancy and the transmitted word.
    always_comb begin
        wr_s  = HIT_WR & ~full_r;
        pop_s = (state_r == ST_IDLE) & read_rise_s & (pending_r != ZERO_P);
        case ({wr_s, pop_s})
            2'b10:   pending_nxt_s = pending_r + ONE_P;
            2'b01:   pending_nxt_s = pending_r - ONE_P;
            default: pending_nxt_s = pending_r;
        endcase
        if (CONF_GRAY_EN) begin
            le_tx_s = le_gray_s;
            te_tx_s = te_gray_s;
        end else begin
            le_tx_s = head_le_s;
            te_tx_s = head_te_s;
        end
        word_s = {head_col_s, le_tx_s, te_tx_s, head_row_s};
    end

    // FIFO, occupancy, loss counter, freeze snapshot and token.
    always_ff @(posedge RX_CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {MONO_WORD_W{1'b0}};
            end
            wr_ptr_r   <= ZERO_P;
            rd_ptr_r   <= ZERO_P;
            pending_r  <= ZERO_P;
            full_r     <= 1'b0;
            lost_cnt_r <= 8'd0;
            read_q_r   <= 1'b0;
            freeze_q_r <= 1'b0;
            frz_cnt_r  <= ZERO_P;
            token_r    <= 1'b0;
        end else begin
            read_q_r   <= RX_READ;
            freeze_q_r <= RX_FREEZE;
            if (wr_s) begin
                mem_r[wr_ptr_r[FIFO_AW-1:0]] <= {HIT_COL, HIT_LE, HIT_TE, HIT_ROW};
                wr_ptr_r <= wr_ptr_r + ONE_P;
            end
            if (HIT_WR && full_r) begin
                lost_cnt_r <= sat_inc8(lost_cnt_r);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_P;
            end
            pending_r <= pending_nxt_s;
            full_r    <= (pending_nxt_s == DEPTH_P);
            // Snapshot excludes a same-cycle write; pops while frozen drain it.
            if (frz_rise_s) begin
                frz_cnt_r <= pending_r;
            end else if (pop_s && freeze_q_r && (frz_cnt_r != ZERO_P)) begin
                frz_cnt_r <= frz_cnt_r - ONE_P;
            end
            token_r <= freeze_q_r ? (frz_cnt_r != ZERO_P) : (pending_r != ZERO_P);
        end
    end

    // Transmit sequencer: load on READ rise, delay after READ fall, shift out.
    always_ff @(posedge RX_CLK) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            shreg_r     <= {MONO_WORD_W{1'b0}};
            dcnt_r      <= 4'd0;
            bcnt_r      <= 5'd0;
            data_r      <= 1'b0;
            empty_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    data_r <= 1'b0;
                    if (read_rise_s) begin
                        // An empty read still transmits an all-zero word.
                        if (pending_r != ZERO_P) begin
                            shreg_r <= word_s;
                        end else begin
                            shreg_r     <= {MONO_WORD_W{1'b0}};
                            empty_cnt_r <= sat_inc8(empty_cnt_r);
                        end
                        state_r <= ST_LOADED;
                    end
                end
                ST_LOADED: begin
                    data_r <= 1'b0;
                    if (read_fall_s) begin
                        dcnt_r  <= DLY_LOAD;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    data_r <= 1'b0;
                    if (dcnt_r == 4'd0) begin
                        bcnt_r  <= TOP_BIT;
                        state_r <= ST_SHIFT;
                    end else begin
                        dcnt_r <= dcnt_r - 4'd1;
                    end
                end
                ST_SHIFT: begin
                    data_r <= shreg_r[bcnt_r];
                    if (bcnt_r == 5'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        bcnt_r <= bcnt_r - 5'd1;
                    end
                end
                default: begin
                    data_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign RX_TOKEN       = token_r;
    assign RX_DATA        = data_r;
    assign HIT_FULL       = full_r;
    assign PENDING        = pending_r;
    assign LOST_CNT       = lost_cnt_r;
    assign EMPTY_READ_CNT = empty_cnt_r;

endmodule

// File: tb/tb_mono_data_tx_emu.sv
// ---------------------------------------------------------------------------
// tb_mono_data_tx_emu
// Directed bench for the MONOPIX readout emulator. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mono_data_tx_emu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hit_wr;
    logic [5:0]  hit_col;
    logic [8:0]  hit_row;
    logic [5:0]  hit_le;
    logic [5:0]  hit_te;
    logic        gray_en;
    logic        rx_freeze;
    logic        rx_read;
    logic        rx_token;
    logic        rx_data;
    logic        hit_full;
    logic [4:0]  pending;
    logic [7:0]  lost_cnt;
    logic [7:0]  empty_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mono_data_tx_emu #(.FIFO_AW(4), .DATA_DELAY(1)) dut (
        .RX_CLK         (clk),
        .RST_N          (rst_n),
        .HIT_WR         (hit_wr),
        .HIT_COL        (hit_col),
        .HIT_ROW        (hit_row),
        .HIT_LE         (hit_le),
        .HIT_TE         (hit_te),
        .CONF_GRAY_EN   (gray_en),
        .RX_FREEZE      (rx_freeze),
        .RX_READ        (rx_read),
        .RX_TOKEN       (rx_token),
        .RX_DATA        (rx_data),
        .HIT_FULL       (hit_full),
        .PENDING        (pending),
        .LOST_CNT       (lost_cnt),
        .EMPTY_READ_CNT (empty_cnt)
    );

    function automatic logic [5:0] gray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [26:0] exp_word(input logic [5:0] col, input logic [8:0] row,
                                             input logic [5:0] le, input logic [5:0] te,
                                             input logic g);
        if (g) return {col, gray(le), gray(te), row};
        else   return {col, le, te, row};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0; hit_wr = 1'b0; hit_col = 6'd0; hit_row = 9'd0;
        hit_le = 6'd0; hit_te = 6'd0; rx_freeze = 1'b0; rx_read = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic write_hit(input logic [5:0] col, input logic [8:0] row,
                             input logic [5:0] le, input logic [5:0] te);
        hit_wr = 1'b1; hit_col = col; hit_row = row; hit_le = le; hit_te = te;
        tick;
        hit_wr = 1'b0;
    endtask

    // READ held for hi_clks edges, then bits 26..stop_bit are captured.
    // With DATA_DELAY=1, bit 26 is visible on the third edge after READ drops.
    task automatic read_word(input int hi_clks, input int stop_bit, output logic [26:0] w);
        w = 27'd0;
        rx_read = 1'b1;
        repeat (hi_clks) tick;
        rx_read = 1'b0;
        tick; tick;
        for (int i = 26; i >= stop_bit; i--) begin
            tick;
            w[i] = rx_data;
        end
    endtask

    task automatic test_reset;
        reset_dut;
        checks++; if (rx_token !== 1'b0) begin errors++; $display("FAIL rst_token: got %b expected 0", rx_token); end
        checks++; if (rx_data !== 1'b0) begin errors++; $display("FAIL rst_data: got %b expected 0", rx_data); end
        checks++; if (pending !== 5'd0) begin errors++; $display("FAIL rst_pending: got %0d expected 0", pending); end
        checks++; if (hit_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", hit_full); end
        checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL rst_lost: got %0d expected 0", lost_cnt); end
        checks++; if (empty_cnt !== 8'd0) begin errors++; $display("FAIL rst_empty: got %0d expected 0", empty_cnt); end
    endtask

    task automatic test_single_hit;
        logic [26:0] w;
        reset_dut;
        gray_en = 1'b1;
        write_hit(6'd5, 9'd300, 6'd12, 6'd20);
        checks++; if (rx_token !== 1'b0) begin errors++; $display("FAIL t1_token_early: got %b expected 0", rx_token); end
        checks++; if (pending !== 5'd1) begin errors++; $display("FAIL t1_pending: got %0d expected 1", pending); end
        tick;
        checks++; if (rx_token !== 1'b1) begin errors++; $display("FAIL t1_token: got %b expected 1", rx_token); end
        read_word(8, 0, w);
        checks++; if (w !== 27'b000101_001010_011110_100101100) begin errors++; $display("FAIL t1_word: got %b expected %b", w, 27'b000101_001010_011110_100101100); end
        checks++; if (rx_token !== 1'b0) begin errors++; $display("FAIL t1_token_drop: got %b expected 0", rx_token); end
        checks++; if (pending !== 5'd0) begin errors++; $display("FAIL t1_pending_end: got %0d expected 0", pending); end
        tick;
        checks++; if (rx_data !== 1'b0) begin errors++; $display("FAIL t1_data_idle: got %b expected 0", rx_data); end
    endtask

    task automatic test_freeze;
        logic [26:0] w;
        logic [26:0] e [3];
        reset_dut;
        gray_en = 1'b1;
        e[0] = exp_word(6'd1, 9'd10, 6'd3, 6'd4, 1'b1);
        e[1] = exp_word(6'd2, 9'd20, 6'd5, 6'd6, 1'b1);
        e[2] = exp_word(6'd3, 9'd30, 6'd7, 6'd8, 1'b1);
        write_hit(6'd1, 9'd10, 6'd3, 6'd4);
        write_hit(6'd2, 9'd20, 6'd5, 6'd6);
        write_hit(6'd3, 9'd30, 6'd7, 6'd8);
        tick;
        rx_freeze = 1'b1;
        tick;
        write_hit(6'd4, 9'd40, 6'd9, 6'd10);
        write_hit(6'd6, 9'd50, 6'd11, 6'd12);
        tick;
        checks++; if (rx_token !== 1'b1) begin errors++; $display("FAIL t2_token_frozen: got %b expected 1", rx_token); end
        checks++; if (pending !== 5'd5) begin errors++; $display("FAIL t2_pending5: got %0d expected 5", pending); end
        for (int k = 0; k < 3; k++) begin
            read_word(1, 0, w);
            checks++; if (w !== e[k]) begin errors++; $display("FAIL t2_word%0d: got %h expected %h", k, w, e[k]); end
            if (k == 1) begin
                checks++; if (rx_token !== 1'b1) begin errors++; $display("FAIL t2_token_mid: got %b expected 1", rx_token); end
            end
        end
        tick;
        checks++; if (rx_token !== 1'b0) begin errors++; $display("FAIL t2_token_drained: got %b expected 0", rx_token); end
        checks++; if (pending !== 5'd2) begin errors++; $display("FAIL t2_pending2: got %0d expected 2", pending); end
        rx_freeze = 1'b0;
        tick;
        checks++; if (rx_token !== 1'b0) begin errors++; $display("FAIL t2_token_unfreeze1: got %b expected 0", rx_token); end
        tick;
        checks++; if (rx_token !== 1'b1) begin errors++; $display("FAIL t2_token_unfreeze2: got %b expected 1", rx_token); end
    endtask

    task automatic test_full;
        logic [26:0] w;
        reset_dut;
        gray_en = 1'b1;
        hit_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            hit_col = 6'(i); hit_row = 9'(i * 7); hit_le = 6'(i); hit_te = 6'(i + 1);
            tick;
            if (i == 14) begin
                checks++; if (hit_full !== 1'b0) begin errors++; $display("FAIL t3_not_full15: got %b expected 0", hit_full); end
            end
        end
        checks++; if (hit_full !== 1'b1) begin errors++; $display("FAIL t3_full: got %b expected 1", hit_full); end
        hit_col = 6'd63; hit_row = 9'd511;
        tick; tick;
        hit_wr = 1'b0;
        checks++; if (lost_cnt !== 8'd2) begin errors++; $display("FAIL t3_lost: got %0d expected 2", lost_cnt); end
        checks++; if (pending !== 5'd16) begin errors++; $display("FAIL t3_pending16: got %0d expected 16", pending); end
        read_word(1, 0, w);
        checks++; if (w !== exp_word(6'd0, 9'd0, 6'd0, 6'd1, 1'b1)) begin errors++; $display("FAIL t3_first_word: got %h expected %h", w, exp_word(6'd0, 9'd0, 6'd0, 6'd1, 1'b1)); end
        checks++; if (pending !== 5'd15 || hit_full !== 1'b0) begin errors++; $display("FAIL t3_after_pop: got %0d/%b expected 15/0", pending, hit_full); end
        hit_wr = 1'b1; rx_read = 1'b1;
        tick;
        hit_wr = 1'b0; rx_read = 1'b0;
        checks++; if (pending !== 5'd15) begin errors++; $display("FAIL t3_wr_pop_same: got %0d expected 15", pending); end
    endtask

    task automatic test_empty_read;
        logic [26:0] w;
        reset_dut;
        read_word(1, 0, w);
        checks++; if (w !== 27'd0) begin errors++; $display("FAIL t4_word: got %h expected 0", w); end
        checks++; if (empty_cnt !== 8'd1) begin errors++; $display("FAIL t4_empty_cnt: got %0d expected 1", empty_cnt); end
        checks++; if (rx_token !== 1'b0) begin errors++; $display("FAIL t4_token: got %b expected 0", rx_token); end
    endtask

    task automatic test_reset_mid_shift;
        logic [26:0] w;
        logic [26:0] e;
        reset_dut;
        gray_en = 1'b1;
        e = exp_word(6'h2A, 9'h155, 6'h15, 6'h2A, 1'b1);
        write_hit(6'h2A, 9'h155, 6'h15, 6'h2A);
        write_hit(6'h11, 9'h0AA, 6'h05, 6'h06);
        read_word(2, 10, w);
        checks++; if (w[26:10] !== e[26:10]) begin errors++; $display("FAIL t5_partial: got %h expected %h", w[26:10], e[26:10]); end
        rst_n = 1'b0;
        tick;
        checks++; if (rx_data !== 1'b0) begin errors++; $display("FAIL t5_data: got %b expected 0", rx_data); end
        checks++; if (rx_token !== 1'b0) begin errors++; $display("FAIL t5_token: got %b expected 0", rx_token); end
        checks++; if (pending !== 5'd0) begin errors++; $display("FAIL t5_pending: got %0d expected 0", pending); end
        rst_n = 1'b1;
        tick;
        read_word(1, 0, w);
        checks++; if (w !== 27'd0 || empty_cnt !== 8'd1) begin errors++; $display("FAIL t5_idle_after: got %h/%0d expected 0/1", w, empty_cnt); end
    endtask

    task automatic test_gray_off;
        logic [26:0] w;
        reset_dut;
        gray_en = 1'b0;
        write_hit(6'd5, 9'd300, 6'd12, 6'd20);
        tick;
        read_word(1, 0, w);
        checks++; if (w[20:15] !== 6'b001100) begin errors++; $display("FAIL t6_le: got %b expected 001100", w[20:15]); end
        checks++; if (w[14:9] !== 6'b010100) begin errors++; $display("FAIL t6_te: got %b expected 010100", w[14:9]); end
        checks++; if (w[26:21] !== 6'd5 || w[8:0] !== 9'd300) begin errors++; $display("FAIL t6_loopback: got col %0d row %0d expected 5 300", w[26:21], w[8:0]); end
    endtask

    initial begin
        gray_en = 1'b1;
        test_reset;
        test_single_hit;
        test_freeze;
        test_full;
        test_empty_read;
        test_reset_mid_shift;
        test_gray_off;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
